// File: rtl/core_pkg.sv
// Shared encodings for the multi-cycle RV32I core: FSM states, major opcodes
// and datapath select values driven by the control sequencer.
package core_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_JAL    = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // States that hold the memory port and therefore may stall on mem_ready.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles in a memory state and flags a timeout once the
// count has reached WAIT_LIMIT while the access is still outstanding.
module mem_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic clear,
  output logic timeout
);

  logic [15:0] count;

  // The compare happens before the increment, so a 16-bit counter never wraps.
  assign timeout = waiting && (count == 16'(WAIT_LIMIT));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || timeout) begin
      count <= '0;
    end else if (waiting) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Control sequencer for the multi-cycle RV32I core: steps each instruction
// through fetch/decode/execute/memory/writeback on a shared memory port.
module multicycle_control_fsm
  import core_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic             bus_error,
  output logic [CNT_W-1:0] instr_count
);

  state_t cur_state;
  state_t next_state;
  logic   waiting;
  logic   timeout;
  logic   retire;

  assign state   = cur_state;
  assign waiting = is_wait_state(cur_state) && !mem_ready;

  mem_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_mem_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .waiting(waiting),
    .clear  (next_state != cur_state),
    .timeout(timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count <= '0;
    end else if (retire) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = cur_state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    illegal_op = 1'b0;
    bus_error  = 1'b0;
    retire     = 1'b0;

    case (cur_state)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BEQ;
          OP_JAL:            next_state = S_JAL;
          default: begin
            next_state = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        next_state = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_EXECR: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALUOP_SUB;
        pc_write   = zero;
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_JAL: begin
        // PC takes the jump target now; ALUWB then writes rd <= OldPC + 4.
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
        next_state = S_ALUWB;
      end
      default: next_state = S_FETCH;
    endcase

    // A timed-out access is abandoned: no strobes, restart at fetch.
    if (timeout) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      bus_error  = 1'b1;
      next_state = S_FETCH;
    end

    // Strobes are masked combinationally so they drop the moment reset rises.
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
      bus_error  = 1'b0;
      retire     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed vector table,
// reset corner sequence, then random traffic against a path-based model.
module tb_multicycle_control_fsm;

  localparam int LIMIT = 4;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    opcode;
  logic          zero;
  logic          mem_ready;
  logic          pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
  logic [1:0]    result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0]    state;
  logic          illegal_op, bus_error;
  logic [CW-1:0] instr_count;

  multicycle_control_fsm #(.WAIT_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state(state), .illegal_op(illegal_op),
    .bus_error(bus_error), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Strobe order: pc_write ir_write mem_read mem_write reg_write illegal_op bus_error
  logic [6:0]  act_strb;
  logic [19:0] act_out;
  assign act_strb = {pc_write, ir_write, mem_read, mem_write, reg_write, illegal_op, bus_error};
  assign act_out  = {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
                     result_src, alu_src_a, alu_src_b, alu_op, state, illegal_op, bus_error};

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [6:0] op;
    logic       z;
    logic       mr;
    logic [3:0] st;
    logic [6:0] strb;
    logic       adr;
    logic [1:0] res;
    logic [7:0] cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [6:0] op, input logic z, input logic mr,
                              input logic [3:0] st, input logic [6:0] strb,
                              input logic adr, input logic [1:0] res, input logic [7:0] cnt);
    return '{op: op, z: z, mr: mr, st: st, strb: strb, adr: adr, res: res, cnt: cnt};
  endfunction

  // Reference model: the rest of the current instruction is a queue of
  // states still to visit; emptying it normally retires the instruction.
  int         mq[$];
  int         m_wait;
  logic [7:0] m_cnt;

  task automatic model_reset();
    mq     = {0, 1};
    m_wait = 0;
    m_cnt  = '0;
  endtask

  task automatic model_step(input logic [6:0] op, input logic z, input logic mr,
                            output logic [19:0] exp);
    int cur;
    logic wt, tmo, ill;
    logic pc, ir, adr, rd, wr, rw;
    logic [1:0] res, sa, sb, ao;
    cur = mq[0];
    wt  = (cur == 0) || (cur == 3) || (cur == 5);
    tmo = wt && !mr && (m_wait == LIMIT);
    ill = 1'b0;
    {pc, ir, adr, rd, wr, rw} = '0;
    {res, sa, sb, ao} = '0;
    case (cur)
      0:  begin rd = 1; sb = 2'b10; res = 2'b10; pc = mr; ir = mr; end
      1:  begin sa = 2'b01; sb = 2'b01;
                ill = !(op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F}); end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  begin adr = 1; rd = 1; end
      4:  begin res = 2'b01; rw = 1; end
      5:  begin adr = 1; wr = 1; end
      6:  begin sa = 2'b10; ao = 2'b10; end
      7:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
      8:  rw = 1;
      9:  begin sa = 2'b10; ao = 2'b01; pc = z; end
      10: begin sa = 2'b01; sb = 2'b10; pc = 1; end
      default: ;
    endcase
    if (tmo) {pc, ir, rd, wr, rw} = '0;
    exp = {pc, ir, adr, rd, wr, rw, res, sa, sb, ao, 4'(cur), ill, tmo};

    if (tmo) begin
      mq = {0, 1};
      m_wait = 0;
    end else if (wt && !mr) begin
      m_wait++;
    end else begin
      m_wait = 0;
      void'(mq.pop_front());
      if (cur == 1) begin
        case (op)
          7'h03:   mq = {2, 3, 4};
          7'h23:   mq = {2, 5};
          7'h33:   mq = {6, 8};
          7'h13:   mq = {7, 8};
          7'h63:   mq = {9};
          7'h6F:   mq = {10, 8};
          default: mq = {0, 1};
        endcase
      end else if (mq.size() == 0) begin
        m_cnt++;
        mq = {0, 1};
      end
    end
  endtask

  function automatic logic [6:0] pick_opcode();
    logic [6:0] legal [6];
    legal = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F};
    if ($urandom_range(0, 7) == 0) return 7'($urandom);
    return legal[$urandom_range(0, 5)];
  endfunction

  initial begin
    logic [19:0] exp;

    // lw; sw with 3 stalls; beq taken/not taken; illegal; fetch timeout;
    // jal; lw completing exactly at the wait limit.
    vq.push_back(mk(7'h03, 0, 1, 0,  7'b1110000, 0, 2'b10, 0));
    vq.push_back(mk(7'h03, 0, 1, 1,  7'b0000000, 0, 2'b00, 0));
    vq.push_back(mk(7'h03, 0, 1, 2,  7'b0000000, 0, 2'b00, 0));
    vq.push_back(mk(7'h03, 0, 1, 3,  7'b0010000, 1, 2'b00, 0));
    vq.push_back(mk(7'h03, 0, 1, 4,  7'b0000100, 0, 2'b01, 0));
    vq.push_back(mk(7'h23, 0, 1, 0,  7'b1110000, 0, 2'b10, 1));
    vq.push_back(mk(7'h23, 0, 1, 1,  7'b0000000, 0, 2'b00, 1));
    vq.push_back(mk(7'h23, 0, 1, 2,  7'b0000000, 0, 2'b00, 1));
    for (int i = 0; i < 3; i++) vq.push_back(mk(7'h23, 0, 0, 5, 7'b0001000, 1, 2'b00, 1));
    vq.push_back(mk(7'h23, 0, 1, 5,  7'b0001000, 1, 2'b00, 1));
    vq.push_back(mk(7'h63, 1, 1, 0,  7'b1110000, 0, 2'b10, 2));
    vq.push_back(mk(7'h63, 1, 1, 1,  7'b0000000, 0, 2'b00, 2));
    vq.push_back(mk(7'h63, 1, 1, 9,  7'b1000000, 0, 2'b00, 2));
    vq.push_back(mk(7'h63, 0, 1, 0,  7'b1110000, 0, 2'b10, 3));
    vq.push_back(mk(7'h63, 0, 1, 1,  7'b0000000, 0, 2'b00, 3));
    vq.push_back(mk(7'h63, 0, 1, 9,  7'b0000000, 0, 2'b00, 3));
    vq.push_back(mk(7'h7F, 0, 1, 0,  7'b1110000, 0, 2'b10, 4));
    vq.push_back(mk(7'h7F, 0, 1, 1,  7'b0000010, 0, 2'b00, 4));
    for (int i = 0; i < LIMIT; i++) vq.push_back(mk(7'h03, 0, 0, 0, 7'b0010000, 0, 2'b10, 4));
    vq.push_back(mk(7'h03, 0, 0, 0,  7'b0000001, 0, 2'b10, 4));
    vq.push_back(mk(7'h6F, 0, 1, 0,  7'b1110000, 0, 2'b10, 4));
    vq.push_back(mk(7'h6F, 0, 1, 1,  7'b0000000, 0, 2'b00, 4));
    vq.push_back(mk(7'h6F, 0, 1, 10, 7'b1000000, 0, 2'b00, 4));
    vq.push_back(mk(7'h6F, 0, 1, 8,  7'b0000100, 0, 2'b00, 4));
    vq.push_back(mk(7'h03, 0, 1, 0,  7'b1110000, 0, 2'b10, 5));
    vq.push_back(mk(7'h03, 0, 1, 1,  7'b0000000, 0, 2'b00, 5));
    vq.push_back(mk(7'h03, 0, 1, 2,  7'b0000000, 0, 2'b00, 5));
    for (int i = 0; i < LIMIT; i++) vq.push_back(mk(7'h03, 0, 0, 3, 7'b0010000, 1, 2'b00, 5));
    vq.push_back(mk(7'h03, 0, 1, 3,  7'b0010000, 1, 2'b00, 5));
    vq.push_back(mk(7'h03, 0, 1, 4,  7'b0000100, 0, 2'b01, 5));
    vq.push_back(mk(7'h03, 0, 1, 0,  7'b1110000, 0, 2'b10, 6));

    // Reset state, with mem_ready high to prove fetch strobes are masked.
    reset = 1'b1; opcode = 7'h03; zero = 1'b0; mem_ready = 1'b1;
    #12;
    check("reset_strobes", act_strb, 7'b0);
    check("reset_state", state, 4'd0);
    check("reset_count", instr_count, 8'd0);
    check("reset_selects", {adr_src, result_src, alu_src_a, alu_src_b, alu_op},
          {1'b0, 2'b10, 2'b00, 2'b10, 2'b00});
    @(negedge clk);
    reset = 1'b0;

    foreach (vq[i]) begin
      opcode = vq[i].op; zero = vq[i].z; mem_ready = vq[i].mr;
      #1;
      check($sformatf("vec%0d", i),
            {act_strb, state, adr_src, result_src, instr_count},
            {vq[i].strb, vq[i].st, vq[i].adr, vq[i].res, vq[i].cnt});
      @(posedge clk); #1;
    end

    // Reset arriving mid-store must kill mem_write at once and clear the count.
    opcode = 7'h23; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1;
    check("memwr_before_reset", {state, mem_write}, {4'd5, 1'b1});
    #1 reset = 1'b1;
    #1;
    check("memwr_async_drop", {state, act_strb}, {4'd0, 7'b0});
    check("reset_clears_count", instr_count, 8'd0);
    @(negedge clk); #1;
    reset = 1'b0; mem_ready = 1'b1;
    #1;
    check("post_reset_fetch", {state, act_strb, instr_count}, {4'd0, 7'b1110000, 8'd0});
    @(posedge clk); #1;
    check("post_reset_decode", state, 4'd1);

    // Random traffic against the model, from a clean reset.
    @(negedge clk);
    reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      if (mq[0] == 0) opcode = pick_opcode();
      zero      = 1'($urandom_range(0, 1));
      mem_ready = ($urandom_range(0, 9) < 6);
      if ((n % 250) < 6) mem_ready = 1'b0;
      #1;
      check($sformatf("rand_count@%0d", n), instr_count, m_cnt);
      model_step(opcode, zero, mem_ready, exp);
      check($sformatf("rand_outputs@%0d", n), act_out, exp);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control sequencer for the multi-cycle RV32I core. It replaces the single-cycle decoder and shares one unified memory port between instruction fetch and data access.
- Walks each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states.
- Drives mux selects, ALU op class and write strobes for PC, IR, register file and memory.
- Handshakes with memory via mem_ready, bounded by a timeout counter.

Parameters:
- WAIT_LIMIT, 255: maximum cycles spent waiting on mem_ready in one memory state; must be 1..65535.
- CNT_W, 32: width of retired-instruction counter.

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-high reset
- opcode  input  7  instr[6:0] from IR
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completed current access this cycle
- pc_write  output  1  PC load strobe
- ir_write  output  1  IR load strobe
- adr_src  output  1  memory address select: 0=PC, 1=ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- reg_write  output  1  register file write strobe
- result_src  output  2  00=ALUOut, 01=mem data, 10=ALU result
- alu_src_a  output  2  00=PC, 01=OldPC, 10=rs1 data
- alu_src_b  output  2  00=rs2 data, 01=ImmExt, 10=constant 4
- alu_op  output  2  00=add, 01=sub/branch, 10=funct decode
- state  output  4  current state encoding, for debug
- illegal_op  output  1  one-cycle pulse on unsupported opcode
- bus_error  output  1  one-cycle pulse on memory timeout
- instr_count  output  CNT_W  retired instruction count

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10.
- Codes 11..15 are unreachable; if entered, next state is FETCH.
- Reset, asynchronous:
  - state=FETCH, wait counter=0, instr_count=0.
  - While reset is high, all strobes are 0: pc_write, ir_write, mem_read, mem_write, reg_write, illegal_op, bus_error.
  - Selects take their FETCH values.
- Selects are a Moore decode of state. The strobes pc_write, ir_write and reg_write are gated as listed per state.

Per-state outputs and transitions (unlisted strobes are 0, unlisted selects are 00):
- FETCH:
  - adr_src=0, mem_read=1, alu_src_b=10, result_src=10.
  - ir_write=pc_write=mem_ready.
  - Next state: DECODE when mem_ready=1, else stay.
- DECODE:
  - alu_src_a=01, alu_src_b=01 (branch target into ALUOut).
  - Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL.
  - Any other opcode -> FETCH, with illegal_op=1 for that cycle.
- MEMADR: alu_src_a=10, alu_src_b=01. Next state: MEMRD if opcode=0000011, else MEMWR.
- MEMRD: adr_src=1, mem_read=1. Next state: MEMWB on mem_ready, else stay.
- MEMWB: result_src=01, reg_write=1. Next state: FETCH.
- MEMWR: adr_src=1, mem_write=1. Next state: FETCH on mem_ready, else stay.
- EXECR: alu_src_a=10, alu_op=10. Next state: ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10. Next state: ALUWB.
- ALUWB: reg_write=1. Next state: FETCH.
- BEQ: alu_src_a=10, alu_op=01, pc_write=zero. Next state: FETCH.
- JAL: alu_src_a=01, alu_src_b=10, pc_write=1 (PC<=ALUOut target). Next state: ALUWB, which writes rd<=OldPC+4.

Wait counter:
- Counts cycles spent in FETCH/MEMRD/MEMWR with mem_ready=0.
- Clears on any state change.
- When it reaches WAIT_LIMIT with mem_ready still 0: bus_error=1 for one cycle, next state=FETCH, no strobes issued that cycle, counter clears.
- mem_ready=1 in the same cycle as the limit wins: normal completion, no bus_error.

instr_count:
- Increments by 1 on transitions MEMWB->FETCH, ALUWB->FETCH, BEQ->FETCH and MEMWR->FETCH on completion.
- Does not increment on illegal or timeout exits.
- Wraps modulo 2^CNT_W.

Decomposition:
- Shared package core_pkg holds:
  - state localparams;
  - opcode constants OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL;
  - select encodings for result_src, alu_src_a, alu_src_b, alu_op.
- One natural sub-module: mem_wait_timer (wait counter plus limit compare, outputs timeout).
- The FSM registers and output decode stay in the top of this block.

Test Plan:
- lw, mem_ready=1 always: states FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH. reg_write high only in MEMWB with result_src=01. instr_count 0->1.
- sw with mem_ready low for 3 cycles in MEMWR: mem_write held 4 cycles, adr_src=1, no reg_write, exits to FETCH on the 4th cycle.
- beq, first with zero=1 then zero=0: pc_write=1 in BEQ only when zero=1. Both cases return to FETCH and increment instr_count.
- Opcode 0x7F: DECODE->FETCH, illegal_op pulses once, instr_count unchanged, no reg_write/mem_write.
- WAIT_LIMIT=4, mem_ready held 0 in FETCH: bus_error pulses after 4 wait cycles, state stays/returns FETCH, ir_write never asserted.
- Reset asserted mid-MEMWR with mem_write=1: mem_write drops immediately (asynchronous). After release: state=0, instr_count=0, fetch restarts.
